// File: rtl/dll_tx_arbiter_if.sv
// dll_tx_arbiter_if
//   Handshake bundle between the three transmit sources (DLLP, replay, new TLP)
//   and the PIPE TX output of the data-link-layer transmit arbiter.
//
//   Signals (direction named from the arbiter's point of view):
//     dllp_valid_i / dllp_data_i / dllp_ready_o            single-beat DLLPs
//     rpl_valid_i / rpl_data_i / rpl_last_i / rpl_ready_o  replayed TLP beats
//     tlp_valid_i / tlp_data_i / tlp_last_i / tlp_ready_o  new TLP beats
//     pipe_txdata_o / pipe_txvalid_o                       registered TX beat
//
//   Modports: slave = arbiter side, master = source / PIPE side.
interface dll_tx_arbiter_if #(
   parameter int PIPE_DATA_WIDTH = 256
);
   logic                       dllp_valid_i;
   logic [PIPE_DATA_WIDTH-1:0] dllp_data_i;
   logic                       dllp_ready_o;

   logic                       rpl_valid_i;
   logic [PIPE_DATA_WIDTH-1:0] rpl_data_i;
   logic                       rpl_last_i;
   logic                       rpl_ready_o;

   logic                       tlp_valid_i;
   logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
   logic                       tlp_last_i;
   logic                       tlp_ready_o;

   logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o;
   logic                       pipe_txvalid_o;

   modport slave (
      input  dllp_valid_i, dllp_data_i,
      output dllp_ready_o,
      input  rpl_valid_i, rpl_data_i, rpl_last_i,
      output rpl_ready_o,
      input  tlp_valid_i, tlp_data_i, tlp_last_i,
      output tlp_ready_o,
      output pipe_txdata_o, pipe_txvalid_o
   );

   modport master (
      output dllp_valid_i, dllp_data_i,
      input  dllp_ready_o,
      output rpl_valid_i, rpl_data_i, rpl_last_i,
      input  rpl_ready_o,
      output tlp_valid_i, tlp_data_i, tlp_last_i,
      input  tlp_ready_o,
      input  pipe_txdata_o, pipe_txvalid_o
   );
endinterface

// File: rtl/dll_tx_arbiter.sv
// dll_tx_arbiter
//   Shares the PIPE transmit datapath between DLLPs, replayed TLPs and new
//   TLPs. Arbitration happens only at packet boundaries and is gated by the
//   DLCM state. Accepted beats appear on the PIPE outputs one cycle later.
//
//   Ports:
//     sclk          clock, rising edge
//     srst          synchronous active-high reset
//     dlcm_state_i  00 DL_INACTIVE, 01 DL_INIT, 10 DL_ACTIVE, 11 as DL_INACTIVE
//     tx            dll_tx_arbiter_if.slave: source handshakes + PIPE TX beat
//     arb_state_o   0 IDLE, 1 NEW, 2 REPLAY
//
//   Optional build macro DLL_TX_ARB_STATS_EN adds wrapping 32-bit counters:
//     stat_tlp_cnt_o, stat_rpl_cnt_o, stat_dllp_cnt_o  completed packets
//     stat_bubble_cnt_o                                 in-packet bubbles
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | packet boundary; arbitrate DLLP / replay / new TLP
//   NEW    | mid new-TLP; only the transaction layer is ready
//   REPLAY | mid replay-TLP; only the retry buffer is ready
module dll_tx_arbiter #(
   parameter int PIPE_DATA_WIDTH = 256,
   parameter int DLLP_MAX_WAIT   = 16,
   parameter int WAIT_CNT_W      = 5
) (
   input  logic                sclk,
   input  logic                srst,
   input  logic [1:0]          dlcm_state_i,
   dll_tx_arbiter_if.slave     tx,
   output logic [1:0]          arb_state_o
`ifdef DLL_TX_ARB_STATS_EN
   ,
   output logic [31:0]         stat_tlp_cnt_o,
   output logic [31:0]         stat_rpl_cnt_o,
   output logic [31:0]         stat_dllp_cnt_o,
   output logic [31:0]         stat_bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_NEW    = 2'd1,
      ST_REPLAY = 2'd2
   } arb_state_t;

   arb_state_t                 state_q;
   arb_state_t                 state_d;
   logic [WAIT_CNT_W-1:0]      wait_cnt_q;

   logic                       dl_active;
   logic                       dl_init;
   logic                       dl_off;
   logic                       dllp_starved;
   logic                       abort;

   logic                       dllp_rdy;
   logic                       rpl_rdy;
   logic                       tlp_rdy;
   logic                       beat_acc;
   logic [PIPE_DATA_WIDTH-1:0] beat_data;

   logic [PIPE_DATA_WIDTH-1:0] txdata_q;
   logic                       txvalid_q;

   assign dl_active = (dlcm_state_i == 2'b10);
   assign dl_init   = (dlcm_state_i == 2'b01);
   assign dl_off    = !(dl_active || dl_init);

   assign dllp_starved = tx.dllp_valid_i &&
                         (wait_cnt_q >= WAIT_CNT_W'(DLLP_MAX_WAIT));

   // Link dropping out of DL_INIT/DL_ACTIVE mid-packet abandons the packet.
   assign abort = (state_q != ST_IDLE) && dl_off;

   always_comb begin
      state_d  = state_q;
      dllp_rdy = 1'b0;
      rpl_rdy  = 1'b0;
      tlp_rdy  = 1'b0;
      if (!srst) begin
         case (state_q)
            ST_IDLE: begin
               if (dl_active) begin
                  if (dllp_starved) begin
                     dllp_rdy = 1'b1;
                  end else if (tx.rpl_valid_i) begin
                     rpl_rdy = 1'b1;
                     if (!tx.rpl_last_i) state_d = ST_REPLAY;
                  end else if (tx.dllp_valid_i) begin
                     dllp_rdy = 1'b1;
                  end else if (tx.tlp_valid_i) begin
                     tlp_rdy = 1'b1;
                     if (!tx.tlp_last_i) state_d = ST_NEW;
                  end
               end else if (dl_init) begin
                  dllp_rdy = tx.dllp_valid_i;
               end
            end
            ST_NEW: begin
               if (dl_off) begin
                  state_d = ST_IDLE;
               end else begin
                  tlp_rdy = tx.tlp_valid_i;
                  if (tx.tlp_valid_i && tx.tlp_last_i) state_d = ST_IDLE;
               end
            end
            ST_REPLAY: begin
               if (dl_off) begin
                  state_d = ST_IDLE;
               end else begin
                  rpl_rdy = tx.rpl_valid_i;
                  if (tx.rpl_valid_i && tx.rpl_last_i) state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Readys are only ever raised alongside their valid, so ready == accept.
   always_comb begin
      beat_acc  = dllp_rdy || rpl_rdy || tlp_rdy;
      beat_data = '0;
      if (dllp_rdy) begin
         beat_data = tx.dllp_data_i;
      end else if (rpl_rdy) begin
         beat_data = tx.rpl_data_i;
      end else if (tlp_rdy) begin
         beat_data = tx.tlp_data_i;
      end
   end

   always_ff @(posedge sclk) begin
      if (srst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         txvalid_q  <= 1'b0;
         txdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         txvalid_q <= beat_acc;
         txdata_q  <= beat_data;
         if (abort || !tx.dllp_valid_i || dllp_rdy) begin
            wait_cnt_q <= '0;
         end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
         end
      end
   end

   assign tx.dllp_ready_o   = dllp_rdy;
   assign tx.rpl_ready_o    = rpl_rdy;
   assign tx.tlp_ready_o    = tlp_rdy;
   assign tx.pipe_txdata_o  = txdata_q;
   assign tx.pipe_txvalid_o = txvalid_q;
   assign arb_state_o       = state_q;

`ifdef DLL_TX_ARB_STATS_EN
   logic [31:0] stat_tlp_q;
   logic [31:0] stat_rpl_q;
   logic [31:0] stat_dllp_q;
   logic [31:0] stat_bubble_q;
   logic        bubble;

   // A bubble is a cycle inside a packet where the owning source has no beat.
   assign bubble = !dl_off &&
                   (((state_q == ST_NEW)    && !tx.tlp_valid_i) ||
                    ((state_q == ST_REPLAY) && !tx.rpl_valid_i));

   always_ff @(posedge sclk) begin
      if (srst) begin
         stat_tlp_q    <= '0;
         stat_rpl_q    <= '0;
         stat_dllp_q   <= '0;
         stat_bubble_q <= '0;
      end else begin
         if (tlp_rdy && tx.tlp_last_i) stat_tlp_q    <= stat_tlp_q + 32'd1;
         if (rpl_rdy && tx.rpl_last_i) stat_rpl_q    <= stat_rpl_q + 32'd1;
         if (dllp_rdy)                 stat_dllp_q   <= stat_dllp_q + 32'd1;
         if (bubble)                   stat_bubble_q <= stat_bubble_q + 32'd1;
      end
   end

   assign stat_tlp_cnt_o    = stat_tlp_q;
   assign stat_rpl_cnt_o    = stat_rpl_q;
   assign stat_dllp_cnt_o   = stat_dllp_q;
   assign stat_bubble_cnt_o = stat_bubble_q;
`endif

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// tb_dll_tx_arbiter
//   Sources are beat queues that hold a beat until it is accepted. A
//   per-cycle reference model applies the arbitration rules (boundary-only
//   arbitration, priority list, DLCM gating, DLLP starvation, abort) and
//   predicts readys, the registered TX beat and the arbiter state.
module tb_dll_tx_arbiter;
   localparam int DW   = 64;
   localparam int MAXW = 4;
   localparam int CW   = 3;
   localparam int SAT  = (1 << CW) - 1;

   logic       sclk = 1'b0;
   logic       srst;
   logic [1:0] dlcm;
   logic [1:0] arb_state;

   dll_tx_arbiter_if #(.PIPE_DATA_WIDTH(DW)) tx ();

`ifdef DLL_TX_ARB_STATS_EN
   logic [31:0] s_tlp, s_rpl, s_dllp, s_bub;
`endif

   dll_tx_arbiter #(
      .PIPE_DATA_WIDTH (DW),
      .DLLP_MAX_WAIT   (MAXW),
      .WAIT_CNT_W      (CW)
   ) dut (
      .sclk         (sclk),
      .srst         (srst),
      .dlcm_state_i (dlcm),
      .tx           (tx.slave),
      .arb_state_o  (arb_state)
`ifdef DLL_TX_ARB_STATS_EN
      ,
      .stat_tlp_cnt_o    (s_tlp),
      .stat_rpl_cnt_o    (s_rpl),
      .stat_dllp_cnt_o   (s_dllp),
      .stat_bubble_cnt_o (s_bub)
`endif
   );

   always #5 sclk = ~sclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // source queues; replay/tlp entries are {last, data}
   logic [DW-1:0] dq[$];
   logic [DW:0]   rq[$];
   logic [DW:0]   tq[$];
   bit en_d = 1, en_r = 1, en_t = 1;

   // reference model state
   int            m_owner = 0;   // 0 none, 1 new TLP, 2 replay
   int            m_wait  = 0;
   bit            m_txv   = 0;
   logic [DW-1:0] m_txd   = '0;
   bit            out_chk = 0;
   logic [DW-1:0] out_q[$];

   task automatic push_pkt(input int src, input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         if (src == 2) rq.push_back({(i == n - 1), base + DW'(i)});
         else          tq.push_back({(i == n - 1), base + DW'(i)});
      end
   endtask

   task automatic step();
      bit dv, rv, tv, rl, tl, gd, gr, gt, off;
      dv = en_d && (dq.size() > 0);
      rv = en_r && (rq.size() > 0);
      tv = en_t && (tq.size() > 0);
      rl = rv ? rq[0][DW] : 1'b0;
      tl = tv ? tq[0][DW] : 1'b0;
      tx.dllp_valid_i = dv;
      tx.dllp_data_i  = dv ? dq[0] : '0;
      tx.rpl_valid_i  = rv;
      tx.rpl_data_i   = rv ? rq[0][DW-1:0] : '0;
      tx.rpl_last_i   = rl;
      tx.tlp_valid_i  = tv;
      tx.tlp_data_i   = tv ? tq[0][DW-1:0] : '0;
      tx.tlp_last_i   = tl;
      #1;
      gd = 0; gr = 0; gt = 0;
      off = !(dlcm == 2'b10 || dlcm == 2'b01);
      if (!srst) begin
         if (m_owner == 0) begin
            if (dlcm == 2'b10) begin
               if (dv && m_wait >= MAXW) gd = 1;
               else if (rv)              gr = 1;
               else if (dv)              gd = 1;
               else if (tv)              gt = 1;
            end else if (dlcm == 2'b01) begin
               gd = dv;
            end
         end else if (!off) begin
            if (m_owner == 1) gt = tv;
            else              gr = rv;
         end
      end
      check_val("ready_drt", {tx.dllp_ready_o, tx.rpl_ready_o, tx.tlp_ready_o}, {gd, gr, gt});
      if (out_chk) begin
         check_val("txvalid", tx.pipe_txvalid_o, m_txv);
         check_val("txdata", tx.pipe_txdata_o, m_txd);
         check_val("arb_state", arb_state, m_owner[1:0]);
         if (tx.pipe_txvalid_o) out_q.push_back(tx.pipe_txdata_o);
      end
      if (srst) begin
         m_owner = 0; m_wait = 0; m_txv = 0; m_txd = '0;
      end else begin
         m_txv = gd | gr | gt;
         if (gd)      m_txd = dq[0];
         else if (gr) m_txd = rq[0][DW-1:0];
         else if (gt) m_txd = tq[0][DW-1:0];
         else         m_txd = '0;
         if (m_owner != 0 && off)  m_wait = 0;
         else if (dv && !gd)       m_wait = (m_wait + 1 > SAT) ? SAT : m_wait + 1;
         else                      m_wait = 0;
         if (m_owner != 0) begin
            if (off || (gt && tl) || (gr && rl)) m_owner = 0;
         end else begin
            if (gr && !rl)      m_owner = 2;
            else if (gt && !tl) m_owner = 1;
         end
      end
      if (gd) void'(dq.pop_front());
      if (gr) void'(rq.pop_front());
      if (gt) void'(tq.pop_front());
      out_chk = 1;
      @(negedge sclk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      srst = 1'b1;
      dlcm = 2'b10;
      @(negedge sclk);

      // reset with every source valid, then priority replay > DLLP > new TLP
      dq.push_back(64'hD0);
      push_pkt(2, 1, 64'hA0);
      push_pkt(1, 1, 64'hB0);
      run(3);
      srst = 1'b0;
      out_q.delete();
      run(5);
      check_val("prio_count", out_q.size(), 3);
      if (out_q.size() == 3) begin
         check_val("prio_first_rpl", out_q[0], 64'hA0);
         check_val("prio_then_dllp", out_q[1], 64'hD0);
         check_val("prio_then_tlp",  out_q[2], 64'hB0);
      end

      // DLLP raised mid new-TLP waits for the boundary
      out_q.delete();
      push_pkt(1, 4, 64'h100);
      step();
      dq.push_back(64'hD1);
      run(8);
      check_val("nonint_count", out_q.size(), 5);
      if (out_q.size() == 5) begin
         check_val("nonint_beat3", out_q[3], 64'h103);
         check_val("nonint_dllp",  out_q[4], 64'hD1);
      end

      // starvation: DLLP overtakes replay once it has waited MAXW cycles
      out_q.delete();
      push_pkt(2, 3, 64'h200);
      push_pkt(2, 3, 64'h210);
      push_pkt(2, 3, 64'h220);
      dq.push_back(64'hD2);
      run(14);
      check_val("starve_count", out_q.size(), 10);
      if (out_q.size() == 10) begin
         check_val("starve_pkt2_end", out_q[5], 64'h212);
         check_val("starve_dllp",     out_q[6], 64'hD2);
         check_val("starve_pkt3",     out_q[7], 64'h220);
      end

      // DL_INIT lets only DLLPs through
      out_q.delete();
      dlcm = 2'b01;
      push_pkt(1, 1, 64'h300);
      dq.push_back(64'hD3);
      run(3);
      check_val("gate_init_count", out_q.size(), 1);
      dlcm = 2'b10;
      run(3);
      check_val("gate_total", out_q.size(), 2);
      if (out_q.size() == 2) check_val("gate_tlp_after", out_q[1], 64'h300);

      // abort: link goes inactive after 3 replay beats
      out_q.delete();
      push_pkt(2, 8, 64'h400);
      run(3);
      dlcm = 2'b00;
      run(6);
      check_val("abort_beats", out_q.size(), 3);
      rq.delete();
      dlcm = 2'b10;
      run(2);

      // DL_INIT mid-packet lets the packet complete
      out_q.delete();
      push_pkt(1, 4, 64'h500);
      run(2);
      dlcm = 2'b01;
      run(6);
      check_val("init_mid_complete", out_q.size(), 4);
      dlcm = 2'b10;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         en_d = ($urandom_range(0, 3) != 0);
         en_r = ($urandom_range(0, 3) != 0);
         en_t = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) < 5) begin
            r = $urandom_range(0, 9);
            dlcm = (r < 7) ? 2'b10 : (r < 8) ? 2'b01 : (r < 9) ? 2'b00 : 2'b11;
         end
         srst = ($urandom_range(0, 399) == 0);
         if (dq.size() < 2 && $urandom_range(0, 9) < 3) dq.push_back({$urandom, $urandom});
         if (rq.size() < 6 && $urandom_range(0, 9) < 2)
            push_pkt(2, $urandom_range(1, 5), {$urandom, $urandom});
         if (tq.size() < 6 && $urandom_range(0, 9) < 3)
            push_pkt(1, $urandom_range(1, 5), {$urandom, $urandom});
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
